// File: rtl/fanout_broadcast_ctrl_if.sv
// fanout_broadcast_ctrl_if: upstream ready/valid plus per-consumer replicated downstream bus
interface fanout_broadcast_ctrl_if #(
    parameter int NUM_OUT    = 9,
    parameter int DATA_WIDTH = 17
);
    logic [DATA_WIDTH-1:0]         in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_OUT*DATA_WIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]            out_valid;
    logic [NUM_OUT-1:0]            out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/fanout_broadcast_ctrl.sv
// fanout_broadcast_ctrl: eager-fork one-entry buffer delivering each token once to every enabled consumer
module fanout_broadcast_ctrl #(
    parameter int NUM_OUT    = 9,
    parameter int DATA_WIDTH = 17,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 cfg_wr_i,
    input  logic [NUM_OUT-1:0]   cfg_en_mask_i,
    output logic                 cfg_err_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] tok_count_o,
    fanout_broadcast_ctrl_if.slave bus
);
    typedef enum logic {EMPTY, HOLD} state_t;
    state_t                state_q, state_d;
    logic [NUM_OUT-1:0]    mask_q, mask_d;
    logic [NUM_OUT-1:0]    done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  hold, all_done, in_ready, capture;
    logic [NUM_OUT-1:0]    out_valid, done_nxt;

    // Per-consumer handshakes, completion detection and next-state selection
    always_comb begin
        hold      = state_q == HOLD;
        out_valid = hold ? mask_q & ~done_q : '0;
        done_nxt  = done_q | (out_valid & bus.out_ready);
        all_done  = (done_nxt & mask_q) == mask_q;
        in_ready  = !hold || all_done;
        capture   = bus.in_valid && in_ready && |mask_q;
        state_d   = state_q;
        done_d    = done_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        mask_d    = (cfg_wr_i && !hold) ? cfg_en_mask_i : mask_q;
        cfg_err_d = cfg_wr_i && hold;
        if (flush_i) begin
            state_d = EMPTY;
            done_d  = '0;
        end else begin
            if (hold) begin
                done_d = done_nxt;
                if (all_done) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = EMPTY;
                end
            end
            if (capture) begin
                state_d = HOLD;
                done_d  = '0;
                data_d  = bus.in_data;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            mask_q    <= '0;
            done_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            done_q    <= done_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = {NUM_OUT{data_q}};
    assign busy_o        = hold;
    assign cfg_err_o     = cfg_err_q;
    assign tok_count_o   = cnt_q;
endmodule

// File: tb/tb_fanout_broadcast_ctrl.sv
// tb_fanout_broadcast_ctrl: directed vector table, random run against a token-level model, corner sequences
module tb_fanout_broadcast_ctrl;
    localparam int N = 9;
    localparam int W = 17;

    logic          clk = 1'b0;
    logic          rst_n, flush, cfg_wr, cfg_err, busy;
    logic [N-1:0]  cfg_mask;
    logic [15:0]   tok_count;
    int            errors = 0;
    int            checks = 0;

    fanout_broadcast_ctrl_if #(.NUM_OUT(N), .DATA_WIDTH(W)) bus ();

    fanout_broadcast_ctrl #(.NUM_OUT(N), .DATA_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .cfg_wr_i      (cfg_wr),
        .cfg_en_mask_i (cfg_mask),
        .cfg_err_o     (cfg_err),
        .busy_o        (busy),
        .tok_count_o   (tok_count),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n, flush, cfg_wr;
        logic [N-1:0] cmask;
        logic         iv;
        logic [W-1:0] d;
        logic [N-1:0] ordy;
        logic         e_ir;
        logic [N-1:0] e_ov;
        logic         e_busy, e_err;
        logic [15:0]  e_cnt;
        logic [W-1:0] e_d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, fl, cw, input logic [N-1:0] cm, input logic iv,
                                input logic [W-1:0] d, input logic [N-1:0] rdy, input logic ir,
                                input logic [N-1:0] ov, input logic b, er, input logic [15:0] c,
                                input logic [W-1:0] ed);
        vec_t v;
        v.rst_n = r; v.flush = fl; v.cfg_wr = cw; v.cmask = cm; v.iv = iv; v.d = d; v.ordy = rdy;
        v.e_ir = ir; v.e_ov = ov; v.e_busy = b; v.e_err = er; v.e_cnt = c; v.e_d = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, fl, cw, input logic [N-1:0] cm, input logic iv,
                         input logic [W-1:0] d, input logic [N-1:0] rdy);
        rst_n = r; flush = fl; cfg_wr = cw; cfg_mask = cm;
        bus.in_valid = iv; bus.in_data = d; bus.out_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Token-level reference: the held token, the consumers still owed it, mask, count
    logic         m_has, m_err;
    logic [W-1:0] m_tok;
    logic [N-1:0] m_owed, m_mask;
    logic [15:0]  m_cnt;

    initial begin
        logic         r, fl, cw, iv, e_ir, m_err_n;
        logic [N-1:0] cm, rdy, e_ov, new_mask;
        logic [W-1:0] d;
        drive(0, 0, 0, '0, 0, '0, '0);
        next_cycle();
        next_cycle();

        tbl.push_back(mk(0,0,0,9'h000,0,17'h0,    9'h000, 1,9'h000,0,0,0,17'h0));
        tbl.push_back(mk(1,0,1,9'h007,0,17'h0,    9'h000, 1,9'h000,0,0,0,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h00A01,9'h1FF, 1,9'h000,0,0,0,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h10A02,9'h1FF, 1,9'h007,1,0,0,17'h00A01));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h00A03,9'h1FF, 1,9'h007,1,0,1,17'h10A02));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h1FA04,9'h1FF, 1,9'h007,1,0,2,17'h00A03));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h1FF, 1,9'h007,1,0,3,17'h1FA04));
        tbl.push_back(mk(1,0,1,9'h003,0,17'h0,    9'h000, 1,9'h000,0,0,4,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h0B0B0,9'h000, 1,9'h000,0,0,4,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h001, 0,9'h003,1,0,4,17'h0B0B0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h002, 1,9'h002,1,0,4,17'h0B0B0));
        tbl.push_back(mk(1,0,1,9'h1FF,0,17'h0,    9'h003, 1,9'h000,0,0,5,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h0C0C0,9'h0FF, 1,9'h000,0,0,5,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h0FF, 0,9'h1FF,1,0,5,17'h0C0C0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,0,9'h000,0,17'h0,9'h0FF, 0,9'h100,1,0,5,17'h0C0C0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h1FF, 1,9'h100,1,0,5,17'h0C0C0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h0D0D0,9'h000, 1,9'h000,0,0,6,17'h0));
        tbl.push_back(mk(1,0,1,9'h001,0,17'h0,    9'h000, 0,9'h1FF,1,0,6,17'h0D0D0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h000, 0,9'h1FF,1,1,6,17'h0D0D0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h1FF, 1,9'h1FF,1,0,6,17'h0D0D0));
        tbl.push_back(mk(1,0,1,9'h001,0,17'h0,    9'h000, 1,9'h000,0,0,7,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h0E0E0,9'h000, 1,9'h000,0,0,7,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h000, 0,9'h001,1,0,7,17'h0E0E0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h001, 1,9'h001,1,0,7,17'h0E0E0));
        tbl.push_back(mk(1,0,1,9'h007,0,17'h0,    9'h000, 1,9'h000,0,0,8,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h0F0F0,9'h000, 1,9'h000,0,0,8,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h001, 0,9'h007,1,0,8,17'h0F0F0));
        tbl.push_back(mk(1,1,0,9'h000,0,17'h0,    9'h000, 0,9'h006,1,0,8,17'h0F0F0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h01234,9'h000, 1,9'h000,0,0,8,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h000, 0,9'h007,1,0,8,17'h01234));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h007, 1,9'h007,1,0,8,17'h01234));
        tbl.push_back(mk(1,0,1,9'h000,0,17'h0,    9'h000, 1,9'h000,0,0,9,17'h0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,0,0,9'h000,1,17'h05555,9'h1FF, 1,9'h000,0,0,9,17'h0));
        tbl.push_back(mk(1,0,1,9'h007,0,17'h0,    9'h000, 1,9'h000,0,0,9,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,1,17'h06666,9'h000, 1,9'h000,0,0,9,17'h0));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h000, 0,9'h007,1,0,9,17'h06666));
        tbl.push_back(mk(0,0,0,9'h000,0,17'h0,    9'h000, 0,9'h007,1,0,9,17'h06666));
        tbl.push_back(mk(1,0,0,9'h000,0,17'h0,    9'h000, 1,9'h000,0,0,0,17'h0));

        foreach (tbl[k]) begin
            drive(tbl[k].rst_n, tbl[k].flush, tbl[k].cfg_wr, tbl[k].cmask, tbl[k].iv, tbl[k].d, tbl[k].ordy);
            @(negedge clk);
            chk($sformatf("row%0d in_ready", k), 32'(bus.in_ready), 32'(tbl[k].e_ir));
            chk($sformatf("row%0d out_valid", k), 32'(bus.out_valid), 32'(tbl[k].e_ov));
            chk($sformatf("row%0d busy", k), 32'(busy), 32'(tbl[k].e_busy));
            chk($sformatf("row%0d cfg_err", k), 32'(cfg_err), 32'(tbl[k].e_err));
            chk($sformatf("row%0d tok_count", k), 32'(tok_count), 32'(tbl[k].e_cnt));
            for (int i = 0; i < N; i++)
                if (tbl[k].e_ov[i])
                    chk($sformatf("row%0d out_data[%0d]", k, i), 32'(bus.out_data[i*W +: W]), 32'(tbl[k].e_d));
            next_cycle();
        end

        // Randomized traffic against the token-level model
        m_has = 0; m_err = 0; m_tok = '0; m_owed = '0; m_mask = '0; m_cnt = '0;
        for (int c = 0; c < 3000; c++) begin
            r   = !(c == 0 || $urandom_range(0, 499) == 0);
            fl  = $urandom_range(0, 49) == 0;
            cw  = $urandom_range(0, 29) == 0;
            cm  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            iv  = cw ? 1'b0 : ($urandom_range(0, 9) < 6);
            d   = W'($urandom);
            rdy = N'($urandom) | N'($urandom);
            drive(r, fl, cw, cm, iv, d, rdy);
            e_ov = m_has ? m_owed : '0;
            e_ir = !m_has || ((m_owed & ~rdy) == '0);
            @(negedge clk);
            if (c > 0) begin
                chk("rnd in_ready", 32'(bus.in_ready), 32'(e_ir));
                chk("rnd out_valid", 32'(bus.out_valid), 32'(e_ov));
                chk("rnd busy", 32'(busy), 32'(m_has));
                chk("rnd cfg_err", 32'(cfg_err), 32'(m_err));
                chk("rnd tok_count", 32'(tok_count), 32'(m_cnt));
                for (int i = 0; i < N; i++)
                    if (e_ov[i] && rdy[i])
                        chk($sformatf("rnd delivered[%0d]", i), 32'(bus.out_data[i*W +: W]), 32'(m_tok));
            end
            if (!r) begin
                m_has = 0; m_err = 0; m_owed = '0; m_mask = '0; m_cnt = '0;
            end else begin
                m_err_n  = cw && m_has;
                new_mask = (cw && !m_has) ? cm : m_mask;
                if (fl) m_has = 0;
                else begin
                    if (m_has && e_ir) begin
                        m_cnt = m_cnt + 16'd1;
                        m_has = 0;
                    end else if (m_has) m_owed = m_owed & ~rdy;
                    if (iv && e_ir && m_mask != '0) begin
                        m_has = 1; m_tok = d; m_owed = new_mask;
                    end
                end
                m_mask = new_mask;
                m_err  = m_err_n;
            end
            next_cycle();
        end

        // A token arriving with the mask write is judged against the old (zero) mask; flush beats completion
        drive(0, 0, 0, '0, 0, '0, '0);
        next_cycle();
        drive(1, 0, 1, 9'h007, 1, 17'h0ABCD, '0);
        @(negedge clk);
        chk("seq in_ready mask0", 32'(bus.in_ready), 32'd1);
        next_cycle();
        drive(1, 0, 0, '0, 0, '0, '0);
        @(negedge clk);
        chk("seq old-mask discard busy", 32'(busy), 32'd0);
        next_cycle();
        drive(1, 0, 0, '0, 1, 17'h13579, '0);
        next_cycle();
        drive(1, 1, 0, '0, 1, 17'h02468, 9'h1FF);
        @(negedge clk);
        chk("seq flush out_valid", 32'(bus.out_valid), 32'h007);
        next_cycle();
        drive(1, 0, 0, '0, 0, '0, '0);
        @(negedge clk);
        chk("seq flush busy", 32'(busy), 32'd0);
        chk("seq flush tok_count", 32'(tok_count), 32'd0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
